logic_unit_pipe: RTL

- Pipelined, parametrised successor to the single-cycle AND/flag unit in the execute stage.
- Performs AND/OR/XOR/NOT/TEST on 8/16/32/full-width operands.
- Generates x86 CF/PF/AF/ZF/SF/OF across two pipeline stages, with valid/ready backpressure.
- Holds an architectural logic-flags register, updated on retirement of flag-writing ops, with a flush path for mispredict recovery.

---
 rtl/logic_unit_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage AND/OR/XOR/NOT/TEST unit with x86 logic flags and a retired-flags register
module logic_unit_pipe #(
  parameter int W    = 32,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [1:0]      in_size,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_result,
  output logic [5:0]      out_flags,
  output logic            out_res_wr,
  output logic            out_flag_wr,
  output logic [TAGW-1:0] out_tag,
  output logic [5:0]      flags_q
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_TEST = 3'b100;

  logic            s1_valid;
  logic [2:0]      s1_op;
  logic [1:0]      s1_size;
  logic [TAGW-1:0] s1_tag;
  logic [W-1:0]    s1_res;

  logic            s2_valid;
  logic [W-1:0]    s2_result;
  logic [5:0]      s2_flags;
  logic            s2_res_wr;
  logic            s2_flag_wr;
  logic [TAGW-1:0] s2_tag;

  logic            s2_adv;
  logic            s1_adv;
  logic [W-1:0]    raw;
  logic [W-1:0]    mask;
  logic            sf;
  logic            zf;
  logic            pf;
  logic            res_wr;
  logic            flag_wr;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    raw = '0;
    case (in_op)
      OP_AND, OP_TEST: raw = in_a & in_b;
      OP_OR:           raw = in_a | in_b;
      OP_XOR:          raw = in_a ^ in_b;
      OP_NOT:          raw = ~in_a;
      default:         raw = '0;
    endcase
  end

  always_comb begin
    mask = '0;
    case (in_size)
      2'b00:   mask[7:0]  = '1;
      2'b01:   mask[15:0] = '1;
      2'b10:   mask[31:0] = '1;
      default: mask       = '1;
    endcase
  end

  // Flags are derived from the already-masked S1 result so S2 only registers them.
  always_comb begin
    sf = 1'b0;
    case (s1_size)
      2'b00:   sf = s1_res[7];
      2'b01:   sf = s1_res[15];
      2'b10:   sf = s1_res[31];
      default: sf = s1_res[W-1];
    endcase
    zf = (s1_res == '0);
    pf = ~^s1_res[7:0];
  end

  always_comb begin
    res_wr  = 1'b0;
    flag_wr = 1'b0;
    case (s1_op)
      OP_AND, OP_OR, OP_XOR: begin
        res_wr  = 1'b1;
        flag_wr = 1'b1;
      end
      OP_TEST: flag_wr = 1'b1;
      OP_NOT:  res_wr  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_size  <= '0;
      s1_tag   <= '0;
      s1_res   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= in_op;
        s1_size <= in_size;
        s1_tag  <= in_tag;
        s1_res  <= raw & mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_flags   <= '0;
      s2_res_wr  <= 1'b0;
      s2_flag_wr <= 1'b0;
      s2_tag     <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result  <= s1_res;
        s2_flags   <= {1'b0, sf, zf, 1'b0, pf, 1'b0};
        s2_res_wr  <= res_wr;
        s2_flag_wr <= flag_wr;
        s2_tag     <= s1_tag;
      end
    end
  end

  // A retiring op commits even when flush is raised in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (s2_valid && out_ready && s2_flag_wr) begin
      flags_q <= s2_flags;
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_flags   = s2_flags;
  assign out_res_wr  = s2_res_wr;
  assign out_flag_wr = s2_flag_wr;
  assign out_tag     = s2_tag;

endmodule
